// File: rtl/plab4_net_domain_tdm_arb_pkg.sv
// Shared plab4 net definitions: domain encodings, counter width, message widths.
package plab4_net_domain_tdm_arb_pkg;

    typedef enum logic {
        DOMAIN_D1 = 1'b0,
        DOMAIN_D2 = 1'b1
    } domain_e;

    localparam int XFER_CNT_NBITS = 16;

    // VC_NET_MSG_NBITS(32,3,3) control width and matching payload width
    localparam int VC_NET_MSG_CNBITS = 44;
    localparam int VC_NET_MSG_DNBITS = 32;

endpackage

// File: rtl/plab4_net_tdm_slot_timer.sv
// Free-running slot counter and owner register; the schedule depends only
// on reset and elapsed cycles.
module plab4_net_tdm_slot_timer
    import plab4_net_domain_tdm_arb_pkg::*;
#(
    parameter int p_slot_cycles = 4
)(
    input  logic clk,
    input  logic reset,
    output logic owner,
    output logic last_cycle
);

    localparam int CW = (p_slot_cycles > 2) ? $clog2(p_slot_cycles) : 1;
    localparam logic [CW-1:0] LAST = CW'(p_slot_cycles - 1);

    logic [CW-1:0] slot_cnt;

    assign last_cycle = (slot_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            owner    <= DOMAIN_D1;
        end else if (last_cycle) begin
            slot_cnt <= '0;
            owner    <= ~owner;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/plab4_net_domain_tdm_arb.sv
// Two-domain TDM arbiter for a shared ring link with per-domain transfer counters.
// Define PLAB4_NET_TDM_GUARD_CYCLE_EN to close the last cycle of every slot.
module plab4_net_domain_tdm_arb
    import plab4_net_domain_tdm_arb_pkg::*;
#(
    parameter int p_msg_cnbits  = VC_NET_MSG_CNBITS,
    parameter int p_msg_dnbits  = VC_NET_MSG_DNBITS,
    parameter int p_slot_cycles = 4
)(
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      in_val_d1,
    output logic                      in_rdy_d1,
    input  logic [p_msg_cnbits-1:0]   in_msg_control_d1,
    input  logic [p_msg_dnbits-1:0]   in_msg_data_d1,

    input  logic                      in_val_d2,
    output logic                      in_rdy_d2,
    input  logic [p_msg_cnbits-1:0]   in_msg_control_d2,
    input  logic [p_msg_dnbits-1:0]   in_msg_data_d2,

    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [p_msg_cnbits-1:0]   out_msg_control,
    output logic [p_msg_dnbits-1:0]   out_msg_data,
    output logic                      out_domain,

    output logic [XFER_CNT_NBITS-1:0] xfer_cnt_d1,
    output logic [XFER_CNT_NBITS-1:0] xfer_cnt_d2
);

`ifdef PLAB4_NET_TDM_GUARD_CYCLE_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic owner;
    logic last_cycle;
    logic open;
    logic owner_d2;
    logic xfer;

    logic [XFER_CNT_NBITS-1:0] cnt_d1;
    logic [XFER_CNT_NBITS-1:0] cnt_d2;

    plab4_net_tdm_slot_timer #(
        .p_slot_cycles (p_slot_cycles)
    ) slot_timer (
        .clk        (clk),
        .reset      (reset),
        .owner      (owner),
        .last_cycle (last_cycle)
    );

    // Reset closes the link immediately, even mid-slot.
    assign open     = !reset && !(GUARD_EN && last_cycle);
    assign owner_d2 = (owner == DOMAIN_D2);

    assign out_domain = reset ? DOMAIN_D1 : owner;

    assign out_val   = open && (owner_d2 ? in_val_d2 : in_val_d1);
    assign in_rdy_d1 = open && !owner_d2 && out_rdy;
    assign in_rdy_d2 = open &&  owner_d2 && out_rdy;

    assign out_msg_control = owner_d2 ? in_msg_control_d2 : in_msg_control_d1;
    assign out_msg_data    = owner_d2 ? in_msg_data_d2    : in_msg_data_d1;

    assign xfer = out_val && out_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_d1 <= '0;
            cnt_d2 <= '0;
        end else if (xfer) begin
            if (owner_d2) cnt_d2 <= cnt_d2 + 1'b1;
            else          cnt_d1 <= cnt_d1 + 1'b1;
        end
    end

    assign xfer_cnt_d1 = cnt_d1;
    assign xfer_cnt_d2 = cnt_d2;

endmodule

// File: tb/tb_plab4_net_domain_tdm_arb.sv
// Randomized self-checking bench for the two-domain TDM link arbiter.
module tb_plab4_net_domain_tdm_arb;

    localparam int P  = 4;
    localparam int CN = 44;
    localparam int DN = 32;

`ifdef PLAB4_NET_TDM_GUARD_CYCLE_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          v1, v2, rdy;
    logic [CN-1:0] c1, c2;
    logic [DN-1:0] d1, d2;
    logic          rdy1, rdy2, oval, odom;
    logic [CN-1:0] oc;
    logic [DN-1:0] od;
    logic [15:0]   cnt1, cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: elapsed cycles since reset and expected counters.
    int          k;
    logic [15:0] m_c1, m_c2;
    bit          trace [10000];

    always #5 clk = ~clk;

    plab4_net_domain_tdm_arb #(
        .p_msg_cnbits  (CN),
        .p_msg_dnbits  (DN),
        .p_slot_cycles (P)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_val_d1         (v1),
        .in_rdy_d1         (rdy1),
        .in_msg_control_d1 (c1),
        .in_msg_data_d1    (d1),
        .in_val_d2         (v2),
        .in_rdy_d2         (rdy2),
        .in_msg_control_d2 (c2),
        .in_msg_data_d2    (d2),
        .out_val           (oval),
        .out_rdy           (rdy),
        .out_msg_control   (oc),
        .out_msg_data      (od),
        .out_domain        (odom),
        .xfer_cnt_d1       (cnt1),
        .xfer_cnt_d2       (cnt2)
    );

    function automatic bit m_owner();
        return ((k / P) % 2) == 1;
    endfunction

    function automatic bit m_open();
        return !(GUARD == 1 && (k % P) == P - 1);
    endfunction

    function automatic bit m_val();
        return m_open() && (m_owner() ? v2 : v1);
    endfunction

    task automatic rand_msgs();
        c1 = CN'({$urandom(), $urandom()});
        c2 = CN'({$urandom(), $urandom()});
        d1 = $urandom();
        d2 = $urandom();
    endtask

    // Advance one cycle, updating the model from the driven inputs.
    task automatic tick();
        if (m_val() && rdy) begin
            if (m_owner()) m_c2 = m_c2 + 16'd1;
            else           m_c1 = m_c1 + 16'd1;
        end
        @(posedge clk);
        k = k + 1;
        #1;
    endtask

    task automatic do_reset();
        v1 = 0; v2 = 0; rdy = 0;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        k = 0;
        m_c1 = 0;
        m_c2 = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        v1 = 1; v2 = 1; rdy = 1;
        rand_msgs();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (oval !== 1'b0 || rdy1 !== 1'b0 || rdy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: val=%b rdy1=%b rdy2=%b want 000",
                     oval, rdy1, rdy2);
        end
        n_checks++;
        if (odom !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dom: got %b want 0", odom);
        end
        n_checks++;
        if (cnt1 !== 16'd0 || cnt2 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h/%h want 0/0", cnt1, cnt2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturated();
        int n1 = 0;
        int n2 = 0;
        do_reset();
        v1 = 1; v2 = 1; rdy = 1;
        for (int i = 0; i < 16; i++) begin
            rand_msgs();
            @(negedge clk);
            n_checks++;
            if (odom !== m_owner()) begin
                n_fail++;
                $display("FAIL sat_dom c%0d: got %b want %b", i, odom, m_owner());
            end
            n_checks++;
            if (oval !== m_val()) begin
                n_fail++;
                $display("FAIL sat_val c%0d: got %b want %b", i, oval, m_val());
            end
            if (m_val()) begin
                n_checks++;
                if (oc !== (m_owner() ? c2 : c1) || od !== (m_owner() ? d2 : d1)) begin
                    n_fail++;
                    $display("FAIL sat_msg c%0d: got %h/%h", i, oc, od);
                end
            end
            n_checks++;
            if (cnt1 !== m_c1 || cnt2 !== m_c2) begin
                n_fail++;
                $display("FAIL sat_cnt c%0d: got %h/%h want %h/%h",
                         i, cnt1, cnt2, m_c1, m_c2);
            end
            if (oval && rdy && rdy1) n1++;
            if (oval && rdy && rdy2) n2++;
            tick();
        end
        n_checks++;
        if (n1 != 2 * (P - GUARD) || n2 != 2 * (P - GUARD)) begin
            n_fail++;
            $display("FAIL sat_total: got %0d/%0d want %0d/%0d",
                     n1, n2, 2 * (P - GUARD), 2 * (P - GUARD));
        end
    endtask

    task automatic test_d2_only();
        int first = -1;
        do_reset();
        v2 = 1; rdy = 1;
        rand_msgs();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 4) begin
                n_checks++;
                if (oval !== 1'b0 || rdy2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL d2_idle c%0d: val=%b rdy2=%b want 00", i, oval, rdy2);
                end
            end
            n_checks++;
            if (odom !== m_owner()) begin
                n_fail++;
                $display("FAIL d2_dom c%0d: got %b want %b", i, odom, m_owner());
            end
            if (oval && rdy2 && first < 0) begin
                first = i;
                n_checks++;
                if (oc !== c2 || od !== d2) begin
                    n_fail++;
                    $display("FAIL d2_msg: got %h/%h want %h/%h", oc, od, c2, d2);
                end
            end
            tick();
        end
        n_checks++;
        if (first != 4) begin
            n_fail++;
            $display("FAIL d2_first: got %0d want 4", first);
        end
    endtask

    task automatic test_stall();
        int acc = -1;
        logic [CN-1:0] hc;
        logic [DN-1:0] hd;
        do_reset();
        rand_msgs();
        hc = c1;
        hd = d1;
        v1 = 1;
        for (int i = 0; i < 12; i++) begin
            rdy = (i >= 4);
            @(negedge clk);
            if (oval && rdy && rdy1 && acc < 0) begin
                acc = i;
                n_checks++;
                if (oc !== hc || od !== hd) begin
                    n_fail++;
                    $display("FAIL stall_msg: got %h/%h want %h/%h", oc, od, hc, hd);
                end
            end
            tick();
            if (acc >= 0) v1 = 0;
        end
        n_checks++;
        if (acc != 8) begin
            n_fail++;
            $display("FAIL stall_accept: got cycle %0d want 8", acc);
        end
        n_checks++;
        if (cnt1 !== m_c1 || m_c1 !== 16'd1) begin
            n_fail++;
            $display("FAIL stall_cnt: got %h model %h want 0001", cnt1, m_c1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        force dut.cnt_d1 = 16'hFFFE;
        release dut.cnt_d1;
        m_c1 = 16'hFFFE;
        tick();
        v1 = 1; rdy = 1;
        for (int i = 0; i < 2; i++) begin
            rand_msgs();
            @(negedge clk);
            n_checks++;
            if (cnt1 !== m_c1) begin
                n_fail++;
                $display("FAIL wrap_step%0d: got %h want %h", i, cnt1, m_c1);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (cnt1 !== 16'h0000 || cnt2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap: got %h/%h want 0000/0000", cnt1, cnt2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        v1 = 1; v2 = 1; rdy = 1;
        rand_msgs();
        repeat (6) tick();
        reset = 1;
        @(negedge clk);
        n_checks++;
        if (oval !== 1'b0 || rdy1 !== 1'b0 || rdy2 !== 1'b0 || odom !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: val=%b rdy=%b%b dom=%b want 0000",
                     oval, rdy1, rdy2, odom);
        end
        @(posedge clk);
        #1;
        reset = 0;
        k = 0;
        m_c1 = 0;
        m_c2 = 0;
        @(negedge clk);
        n_checks++;
        if (odom !== 1'b0 || oval !== 1'b1 || rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_after: dom=%b val=%b rdy1=%b want 011", odom, oval, rdy1);
        end
        n_checks++;
        if (cnt1 !== 16'd0 || cnt2 !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_cnt: got %h/%h want 0/0", cnt1, cnt2);
        end
        tick();
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            void'($urandom(32'h1234 + s * 977));
            do_reset();
            for (int i = 0; i < 10000; i++) begin
                v1  = 1'($urandom_range(0, 1));
                v2  = 1'($urandom_range(0, 1));
                rdy = 1'($urandom_range(0, 1));
                rand_msgs();
                @(negedge clk);
                n_checks++;
                if (odom !== m_owner() || oval !== m_val()
                    || rdy1 !== (m_open() && !m_owner() && rdy)
                    || rdy2 !== (m_open() && m_owner() && rdy)) begin
                    n_fail++;
                    $display("FAIL rand s%0d c%0d: dom=%b val=%b rdy=%b%b",
                             s, i, odom, oval, rdy1, rdy2);
                end
                if (m_val()) begin
                    n_checks++;
                    if (oc !== (m_owner() ? c2 : c1) || od !== (m_owner() ? d2 : d1)) begin
                        n_fail++;
                        $display("FAIL rand_msg s%0d c%0d: got %h/%h", s, i, oc, od);
                    end
                end
                if (s == 0) begin
                    trace[i] = odom;
                end else begin
                    n_checks++;
                    if (odom !== trace[i]) begin
                        n_fail++;
                        $display("FAIL rand_repeat s%0d c%0d: got %b want %b",
                                 s, i, odom, trace[i]);
                    end
                end
                tick();
            end
            @(negedge clk);
            n_checks++;
            if (cnt1 !== m_c1 || cnt2 !== m_c2) begin
                n_fail++;
                $display("FAIL rand_cnt s%0d: got %h/%h want %h/%h",
                         s, cnt1, cnt2, m_c1, m_c2);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1;
        v1 = 0; v2 = 0; rdy = 0;
        c1 = '0; c2 = '0; d1 = '0; d2 = '0;
        k = 0; m_c1 = 0; m_c2 = 0;
        test_reset();
        test_saturated();
        test_d2_only();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plab4_net_domain_tdm_arb.md
PLAB4_NET_DOMAIN_TDM_ARB -- requirements
Module: plab4_net_domain_tdm_arb

Interface
REQ-001 p_msg_cnbits, default 44, SHALL set the control message width (VC_NET_MSG_NBITS(32,3,3)).
REQ-002 p_msg_dnbits, default 32, SHALL set the data payload width.
REQ-003 p_slot_cycles, default 4, SHALL set the slot length in cycles; legal range 2..256.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be synchronous and active-high.
REQ-006 in_val_d1 / in_rdy_d1  input/output  1/1  SHALL be the domain-1 (low) requester handshake.
REQ-007 in_msg_control_d1 / in_msg_data_d1  input  p_msg_cnbits/p_msg_dnbits  SHALL be the domain-1 message.
REQ-008 in_val_d2 / in_rdy_d2 / in_msg_control_d2 / in_msg_data_d2 SHALL be the domain-2 (high) equivalents, same directions and widths.
REQ-009 out_val / out_rdy  output/input  1/1  SHALL be the shared ring link handshake.
REQ-010 out_msg_control / out_msg_data  output  p_msg_cnbits/p_msg_dnbits  SHALL be the shared link message.
REQ-011 out_domain  output  1  SHALL tag the link: 0 = d1, 1 = d2, matching the downstream demux select.
REQ-012 xfer_cnt_d1 / xfer_cnt_d2  output  16 each  SHALL count completed link transfers per domain.

Function
REQ-013 Block SHALL hold slot_cnt (0..p_slot_cycles-1) and owner (0 = d1, 1 = d2); slot_cnt increments every cycle.
REQ-014 When slot_cnt == p_slot_cycles-1, slot_cnt SHALL wrap to 0 and owner SHALL toggle on the same edge.
REQ-015 Owner schedule SHALL depend only on reset and elapsed cycles, never on any val, rdy or message input (no work conservation).
REQ-016 In an open cycle: out_val = in_val of owner; out_msg_* = owner's msg_*; owner's in_rdy = out_rdy; non-owner in_rdy = 0; all combinational, zero latency.
REQ-017 out_domain SHALL equal owner in every cycle, including closed and idle cycles.
REQ-018 Transfer SHALL occur only when out_val && out_rdy; the non-owner's val SHALL be ignored and its message never driven.
REQ-019 A message still pending (val high, not accepted) at slot end SHALL stay with its requester until that domain's next slot; no partial or cross-slot transfer.
REQ-020 On each transfer, the owner's xfer_cnt SHALL increment by 1, wrapping 0xFFFF -> 0x0000; the other counter SHALL hold.
REQ-021 out_msg_* SHALL be don't-care when out_val = 0; verification checks them only when out_val = 1.

Reset
REQ-022 While reset = 1: slot_cnt = 0, owner = 0, counters = 0, out_val = 0, in_rdy_d1 = in_rdy_d2 = 0, out_domain = 0.
REQ-023 First cycle after reset deasserts SHALL be slot_cnt 0 of a d1 slot; reset mid-slot SHALL abandon the current slot with no transfer in the reset cycle.

Configuration
REQ-024 Macro PLAB4_NET_TDM_GUARD_CYCLE_EN SHALL, when defined, make cycle slot_cnt == p_slot_cycles-1 a closed guard cycle: out_val = 0, both in_rdy = 0, no counter change.
REQ-025 Without the macro, every cycle SHALL be open; with it, p_slot_cycles SHALL be >= 2 and each slot gives p_slot_cycles-1 open cycles.

Structure
REQ-026 Domain encodings (DOMAIN_D1 = 0, DOMAIN_D2 = 1) and the counter width (16) SHALL be defined in the shared plab4 net package header; message widths SHALL come from VC_NET_MSG_NBITS.
REQ-027 Slot counter and owner register SHALL form sub-module plab4_net_tdm_slot_timer, outputs owner and last_cycle; the top level holds the muxing and counters.

Verification (p_slot_cycles = 4)
REQ-028 Reset, then both val = 1 and out_rdy = 1 constantly -> out_domain 0,0,0,0,1,1,1,1,0...; without the macro 4 d1 then 4 d2 transfers per 8 cycles; with it 3 + 3, no transfer at cycles 3 and 7.
REQ-029 Only in_val_d2 = 1 from cycle 0 -> out_val = 0 and in_rdy_d2 = 0 in cycles 0-3; first d2 transfer in cycle 4 carrying d2 control/data; owner still toggles at cycle 4 with d1 idle.
REQ-030 d1 val = 1 and out_rdy = 0 through cycle 3, out_rdy = 1 from cycle 4 -> no d1 transfer in cycles 0-7; d1 message accepted in cycle 8 unchanged.
REQ-031 Preload xfer_cnt_d1 near 0xFFFE via saturated d1 traffic -> after 2 further d1 transfers it reads 0x0000; xfer_cnt_d2 unchanged.
REQ-032 Assert reset in cycle 6 (d2 slot) with both val high -> no transfer in cycle 6; cycle 7 is d1 slot_cnt 0; counters read 0.
REQ-033 Random val/out_rdy for 10k cycles across 3 seeds -> owner sequence identical in every run.
